pulse_freq_meter: RTL and testbench



---
 rtl/pulse_pkg.sv | 18 +
 rtl/pulse_sync_edge.sv | 28 ++
 rtl/pulse_freq_meter.sv | 154 +++++++++++++++
 tb/tb_pulse_freq_meter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared constants for the stepper pulse generator and its meter.
// Mode codes, meter FSM states and the system clock rate.
package pulse_pkg;

  localparam int CLK_HZ = 100000000;

  localparam logic [1:0] MODE_32    = 2'b00;
  localparam logic [1:0] MODE_64    = 2'b01;
  localparam logic [1:0] MODE_128   = 2'b10;
  localparam logic [1:0] MODE_OTHER = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detect.
// An input rise shows up as a 1-cycle pulse on rise three clocks later.
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic meta;
  logic sync_q;
  logic sync_qq;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta    <= 1'b0;
      sync_q  <= 1'b0;
      sync_qq <= 1'b0;
      rise    <= 1'b0;
    end else begin
      meta    <= din;
      sync_q  <= meta;
      sync_qq <= sync_q;
      rise    <= sync_q & ~sync_qq;
    end
  end

endmodule

// File: rtl/pulse_freq_meter.sv
// Gated rising-edge counter with period capture and classification
// of the measured rate into the pulse generator's mode codes.
module pulse_freq_meter
  import pulse_pkg::*;
#(
  parameter int GATE_CYCLES = CLK_HZ,
  parameter int CNT_W       = 16,
  parameter int PER_W       = 32,
  parameter int F0          = 32,
  parameter int F1          = 64,
  parameter int F2          = 128,
  parameter int TOL         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic [1:0]       mode_det,
  output logic             mode_match,
  output logic             overflow,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             busy
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int FW = $clog2(F2 + TOL + 1) + 1;
  localparam int CW = (CNT_W + 1 > FW) ? CNT_W + 1 : FW;

  localparam logic [GW-1:0]    G_LAST  = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PER_W-1:0] PER_MAX = '1;

  localparam logic [CW-1:0] LO0 = CW'((F0 > TOL) ? F0 - TOL : 0);
  localparam logic [CW-1:0] HI0 = CW'(F0 + TOL);
  localparam logic [CW-1:0] LO1 = CW'((F1 > TOL) ? F1 - TOL : 0);
  localparam logic [CW-1:0] HI1 = CW'(F1 + TOL);
  localparam logic [CW-1:0] LO2 = CW'((F2 > TOL) ? F2 - TOL : 0);
  localparam logic [CW-1:0] HI2 = CW'(F2 + TOL);

  if (F0 + TOL >= F1 - TOL || F1 + TOL >= F2 - TOL) begin : g_tol_chk
    $error("pulse_freq_meter: classification windows overlap");
  end

  state_t           state;
  logic             pulse_edge;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             ovf_int;
  logic [CW-1:0]    cnt_x;
  logic [1:0]       mode_c;
  logic [PER_W-1:0] per_cnt;
  logic             armed;

  pulse_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pulse_in),
    .rise (pulse_edge)
  );

  // Widened so F-TOL never wraps below zero
  always_comb begin
    cnt_x  = CW'(edge_cnt);
    mode_c = MODE_OTHER;
    unique case (1'b1)
      (cnt_x >= LO0 && cnt_x <= HI0): mode_c = MODE_32;
      (cnt_x >= LO1 && cnt_x <= HI1): mode_c = MODE_64;
      (cnt_x >= LO2 && cnt_x <= HI2): mode_c = MODE_128;
      default:                        mode_c = MODE_OTHER;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf_int    <= 1'b0;
      freq       <= '0;
      freq_valid <= 1'b0;
      mode_det   <= MODE_OTHER;
      mode_match <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf_int  <= 1'b0;
          if (enable) state <= GATE;
        end
        GATE: begin
          if (!enable) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_int  <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            if (pulse_edge) begin
              if (edge_cnt == CNT_MAX) ovf_int <= 1'b1;
              else edge_cnt <= edge_cnt + CNT_W'(1);
            end
            if (gate_cnt == G_LAST) state <= REPORT;
          end
        end
        REPORT: begin
          freq       <= edge_cnt;
          overflow   <= ovf_int;
          mode_det   <= mode_c;
          mode_match <= (mode_c != MODE_OTHER);
          freq_valid <= 1'b1;
          gate_cnt   <= '0;
          ovf_int    <= 1'b0;
          // The dead cycle's edge belongs to the following gate
          edge_cnt   <= (enable && pulse_edge) ? CNT_W'(1) : '0;
          state      <= enable ? GATE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt      <= '0;
      armed        <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!enable) begin
        per_cnt <= '0;
        armed   <= 1'b0;
      end else if (pulse_edge) begin
        per_cnt <= '0;
        armed   <= 1'b1;
        if (armed) begin
          period       <= (per_cnt == PER_MAX) ? PER_MAX : per_cnt + PER_W'(1);
          period_valid <= 1'b1;
        end
      end else if (per_cnt != PER_MAX) begin
        per_cnt <= per_cnt + PER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pulse_freq_meter.sv
// Bench for pulse_freq_meter: random-phase pulse trains against a
// window-counting reference model, on a 16-bit and a 4-bit instance.
module tb_pulse_freq_meter;
  import pulse_pkg::*;

  localparam int GC  = 10000;
  localparam int GP  = GC + 1;
  localparam int F0  = 32;
  localparam int F1  = 64;
  localparam int F2  = 128;
  localparam int TOL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        pulse_in = 1'b0;

  logic [15:0] freq;
  logic        freq_valid;
  logic [1:0]  mode_det;
  logic        mode_match;
  logic        overflow;
  logic [31:0] period;
  logic        period_valid;
  logic        busy;

  logic [3:0]  freq4;
  logic        freq_valid4;
  logic [1:0]  mode4;
  logic        match4;
  logic        ovf4;
  logic [31:0] period4;
  logic        period_valid4;
  logic        busy4;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int per = 0;
  int hi = 0;
  int next_rise = -1;
  int fall_at = -1;
  int inj_q[$];
  bit rise_at[int];

  int last_t = -1;
  int g0 = 0;
  int ng = 0;

  int   e_freq = 0;
  int   e_f4 = 0;
  logic [1:0] e_mode = MODE_OTHER;
  logic e_ovf = 1'b0;
  logic e_ovf4 = 1'b0;

  pulse_freq_meter #(
    .GATE_CYCLES (GC),
    .CNT_W       (16),
    .TOL         (TOL)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .pulse_in     (pulse_in),
    .freq         (freq),
    .freq_valid   (freq_valid),
    .mode_det     (mode_det),
    .mode_match   (mode_match),
    .overflow     (overflow),
    .period       (period),
    .period_valid (period_valid),
    .busy         (busy)
  );

  pulse_freq_meter #(
    .GATE_CYCLES (GC),
    .CNT_W       (4),
    .TOL         (TOL)
  ) u_small (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .pulse_in     (pulse_in),
    .freq         (freq4),
    .freq_valid   (freq_valid4),
    .mode_det     (mode4),
    .mode_match   (match4),
    .overflow     (ovf4),
    .period       (period4),
    .period_valid (period_valid4),
    .busy         (busy4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int cls(input int v);
    if (v >= F0 - TOL && v <= F0 + TOL) return 0;
    if (v >= F1 - TOL && v <= F1 + TOL) return 1;
    if (v >= F2 - TOL && v <= F2 + TOL) return 2;
    return 3;
  endfunction

  // Internal edges land 4 posedges after the rise is driven
  function automatic int count_edges(input int gi);
    int lo;
    int hi_b;
    int n;
    lo   = (gi == 0) ? g0 + 2 : g0 + GC + 2 + (gi - 1) * GP;
    hi_b = g0 + GC + 1 + gi * GP;
    n = 0;
    foreach (rise_at[r]) if (r + 4 >= lo && r + 4 <= hi_b) n++;
    return n;
  endfunction

  task automatic set_per(input int p);
    pulse_in = 1'b0;
    per = p;
    fall_at = -1;
    next_rise = -1;
    if (p > 0) begin
      hi = $urandom_range(p - 2, 2);
      next_rise = cyc + 3 + $urandom_range(p - 1, 0);
    end
  endtask

  task automatic tick();
    int  c;
    int  d;
    int  k;
    int  n;
    int  e16;
    int  e4;
    bit  pv;
    bit  fv;
    @(negedge clk);
    c  = cyc;
    pv = 1'b0;
    d  = 0;
    if (rst || !enable) last_t = -1;
    else if (rise_at.exists(c - 4)) begin
      if (last_t >= 0) begin
        pv = 1'b1;
        d  = c - last_t;
      end
      last_t = c;
    end
    if (pv || period_valid !== 1'b0 || period_valid4 !== 1'b0) begin
      chk("period_valid", period_valid, pv);
      chk("period_valid4", period_valid4, pv);
      if (pv) begin
        chk("period", period, d);
        chk("period4", period4, d);
      end
    end
    k  = c - g0 - GC - 2;
    fv = (ng > 0 && k >= 0 && k % GP == 0 && k / GP < ng);
    if (fv || freq_valid !== 1'b0 || freq_valid4 !== 1'b0) begin
      chk("freq_valid", freq_valid, fv);
      chk("freq_valid4", freq_valid4, fv);
      if (fv) begin
        n   = count_edges(k / GP);
        e16 = (n > 65535) ? 65535 : n;
        e4  = (n > 15) ? 15 : n;
        e_freq = e16;
        e_f4   = e4;
        e_mode = 2'(cls(e16));
        e_ovf  = (n > 65535);
        e_ovf4 = (n > 15);
        chk("freq", freq, e16);
        chk("mode_det", mode_det, e_mode);
        chk("mode_match", mode_match, cls(e16) != 3);
        chk("overflow", overflow, e_ovf);
        chk("freq4", freq4, e4);
        chk("mode4", mode4, cls(e4));
        chk("match4", match4, cls(e4) != 3);
        chk("ovf4", ovf4, e_ovf4);
      end
    end
    if (per > 0 && c == next_rise) begin
      pulse_in   = 1'b1;
      rise_at[c] = 1'b1;
      fall_at    = c + hi;
      next_rise  = c + per;
    end else if (inj_q.size() > 0 && c == inj_q[0]) begin
      void'(inj_q.pop_front());
      pulse_in   = 1'b1;
      rise_at[c] = 1'b1;
      fall_at    = c + 3;
    end else if (c == fall_at) begin
      pulse_in = 1'b0;
    end
  endtask

  task automatic check_reset(input string t);
    chk({t, ".freq"}, freq, 0);
    chk({t, ".freq_valid"}, freq_valid, 0);
    chk({t, ".mode_det"}, mode_det, MODE_OTHER);
    chk({t, ".mode_match"}, mode_match, 0);
    chk({t, ".overflow"}, overflow, 0);
    chk({t, ".period"}, period, 0);
    chk({t, ".period_valid"}, period_valid, 0);
    chk({t, ".busy"}, busy, 0);
    chk({t, ".freq4"}, freq4, 0);
    chk({t, ".mode4"}, mode4, MODE_OTHER);
    chk({t, ".ovf4"}, ovf4, 0);
    chk({t, ".busy4"}, busy4, 0);
  endtask

  task automatic check_hold(input string t);
    chk({t, ".freq"}, freq, e_freq);
    chk({t, ".mode_det"}, mode_det, e_mode);
    chk({t, ".overflow"}, overflow, e_ovf);
    chk({t, ".freq4"}, freq4, e_f4);
    chk({t, ".ovf4"}, ovf4, e_ovf4);
  endtask

  task automatic go(input int n);
    ng = n;
    g0 = cyc;
    enable = 1'b1;
  endtask

  task automatic wait_done();
    while (cyc < g0 + GC + 2 + (ng - 1) * GP) tick();
    enable = 1'b0;
    repeat (20) tick();
    chk("busy_done", busy, 0);
  endtask

  task automatic run(input int p, input int n);
    set_per(p);
    repeat (10) tick();
    go(n);
    wait_done();
  endtask

  initial begin
    set_per(20);
    repeat (5) tick();
    check_reset("rst");
    rst = 1'b0;
    repeat (40) tick();
    check_reset("idle");

    run(312, 1);
    run(156, 1);
    run(78, 1);
    run(200, 1);
    run(100, 1);

    set_per(1000);
    repeat (10) tick();
    go(0);
    while (cyc < g0 + 5001) tick();
    chk("busy_gate", busy, 1);
    enable = 1'b0;
    tick();
    chk("busy_abort", busy, 0);
    check_hold("abort");
    repeat (3) tick();
    go(1);
    wait_done();

    set_per(0);
    repeat (10) tick();
    go(2);
    inj_q.push_back(g0 + GC - 2);
    inj_q.push_back(g0 + GC - 3 + GP);
    wait_done();

    set_per(156);
    repeat (10) tick();
    go(0);
    repeat (500) tick();
    chk("busy_mid", busy, 1);
    rst = 1'b1;
    enable = 1'b0;
    tick();
    check_reset("midrst");
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_reset("postrst");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
